// File: rtl/cam_i2c_sched.sv
// Camera sensor I2C write scheduler.
// Walks an init table (power-up delay, then one I2C write per entry with up
// to three attempts each), then serves runtime host writes one at a time.
// Handshake with the I2C master: m_start rises with m_data already stable
// and stays high until the master reports m_tr_end (or the per-transfer
// timeout expires). A new m_start only rises after m_tr_end has been seen
// low again. The host side is a request/grant pair: host_req is held until
// the one-cycle host_gnt, which is also the cycle host_data is captured.
module cam_i2c_sched #(
  parameter logic [7:0] DEV_ADDR = 8'h78,
  parameter int         TBL_LEN  = 256,
  parameter int         PWR_DLY  = 25000,
  parameter int         TMO      = 2000000
) (
  input  logic        clk_25M,
  input  logic        camera_rstn,
  input  logic        init_req,
  output logic [8:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  input  logic        host_req,
  input  logic [23:0] host_data,
  output logic        host_gnt,
  output logic        host_done,
  output logic        host_err,
  output logic        m_start,
  output logic [31:0] m_data,
  input  logic        m_tr_end,
  input  logic        m_ack,
  output logic        conf_done,
  output logic        init_err,
  output logic        busy
);

  // One shared down-time counter serves both the power-up wait and the
  // per-transfer timeout, so it is sized for the larger of the two.
  localparam int CNT_MAX = (PWR_DLY > TMO) ? PWR_DLY : TMO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO - 1);
  localparam logic [8:0]       ADDR_LAST = 9'(TBL_LEN - 1);
  localparam logic [1:0]       RETRY_MAX = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_END = 3'd3,
    S_WAIT_LOW = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [8:0]        tbl_addr_q, tbl_addr_d;
  logic [1:0]        retry_q, retry_d;
  logic              fail_q, fail_d;
  logic              host_mode_q, host_mode_d;
  logic [23:0]       host_buf_q, host_buf_d;
  logic              m_start_q, m_start_d;
  logic [31:0]       m_data_q, m_data_d;
  logic              conf_done_q, conf_done_d;
  logic              init_err_q, init_err_d;
  logic              host_done_q, host_done_d;
  logic              host_err_q, host_err_d;
  logic              host_gnt_c;
  logic              start_init_c;

  logic              te_meta_q, te_s;
  logic              ack_meta_q, ack_s;

  // Two-flop synchronizers for the master's status lines.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      te_meta_q  <= 1'b0;
      te_s       <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s      <= 1'b0;
    end else begin
      te_meta_q  <= m_tr_end;
      te_s       <= te_meta_q;
      ack_meta_q <= m_ack;
      ack_s      <= ack_meta_q;
    end
  end

  // State and datapath registers; reset also kills any transfer in flight.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tbl_addr_q  <= '0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      host_mode_q <= 1'b0;
      host_buf_q  <= '0;
      m_start_q   <= 1'b0;
      m_data_q    <= '0;
      conf_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      host_done_q <= 1'b0;
      host_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tbl_addr_q  <= tbl_addr_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      host_mode_q <= host_mode_d;
      host_buf_q  <= host_buf_d;
      m_start_q   <= m_start_d;
      m_data_q    <= m_data_d;
      conf_done_q <= conf_done_d;
      init_err_q  <= init_err_d;
      host_done_q <= host_done_d;
      host_err_q  <= host_err_d;
    end
  end

  // Next-state and datapath decisions for the whole sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tbl_addr_d   = tbl_addr_q;
    retry_d      = retry_q;
    fail_d       = fail_q;
    host_mode_d  = host_mode_q;
    host_buf_d   = host_buf_q;
    m_start_d    = m_start_q;
    m_data_d     = m_data_q;
    conf_done_d  = conf_done_q;
    init_err_d   = init_err_q;
    host_done_d  = 1'b0;
    host_err_d   = 1'b0;
    host_gnt_c   = 1'b0;
    start_init_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_req) start_init_c = 1'b1;
      end

      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ISSUE: begin
        m_data_d  = host_mode_q ? {DEV_ADDR, host_buf_q} : {DEV_ADDR, tbl_data};
        m_start_d = 1'b1;
        cnt_d     = '0;
        fail_d    = 1'b0;
        state_d   = S_WAIT_END;
      end

      S_WAIT_END: begin
        // A real end-of-transfer takes priority over a coincident timeout.
        if (te_s) begin
          fail_d    = ack_s;
          m_start_d = 1'b0;
          state_d   = S_WAIT_LOW;
        end else if (cnt_q == TMO_LAST) begin
          fail_d    = 1'b1;
          m_start_d = 1'b0;
          state_d   = S_WAIT_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_LOW: begin
        if (!te_s) state_d = S_NEXT;
      end

      S_NEXT: begin
        if (host_mode_q) begin
          host_done_d = 1'b1;
          host_err_d  = fail_q;
          host_mode_d = 1'b0;
          state_d     = S_DONE;
        end else if (fail_q && (retry_q != RETRY_MAX)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          retry_d = '0;
          if (fail_q) init_err_d = 1'b1;
          if (tbl_addr_q == ADDR_LAST) begin
            conf_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            tbl_addr_d = tbl_addr_q + 9'd1;
            state_d    = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        // Host traffic wins over an init restart requested in the same cycle.
        if (host_req) begin
          host_gnt_c  = 1'b1;
          host_buf_d  = host_data;
          host_mode_d = 1'b1;
          state_d     = S_ISSUE;
        end else if (init_req) begin
          start_init_c = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start_init_c) begin
      tbl_addr_d  = '0;
      retry_d     = '0;
      conf_done_d = 1'b0;
      init_err_d  = 1'b0;
      host_mode_d = 1'b0;
      cnt_d       = '0;
      state_d     = S_PWR_WAIT;
    end
  end

  assign tbl_addr  = tbl_addr_q;
  assign host_gnt  = host_gnt_c;
  assign host_done = host_done_q;
  assign host_err  = host_err_q;
  assign m_start   = m_start_q;
  assign m_data    = m_data_q;
  assign conf_done = conf_done_q;
  assign init_err  = init_err_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_cam_i2c_sched.sv
// Directed bench for cam_i2c_sched with a small reactive I2C master model.
module tb_cam_i2c_sched;

  localparam int TBL_LEN = 4;
  localparam int PWR_DLY = 10;
  localparam int TMO     = 100;

  logic        clk_25M = 1'b0;
  logic        camera_rstn = 1'b0;
  logic        init_req = 1'b0;
  logic [8:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic        host_req = 1'b0;
  logic [23:0] host_data = 24'h0;
  logic        host_gnt;
  logic        host_done;
  logic        host_err;
  logic        m_start;
  logic [31:0] m_data;
  logic        m_tr_end;
  logic        m_ack;
  logic        conf_done;
  logic        init_err;
  logic        busy;

  cam_i2c_sched #(
    .DEV_ADDR (8'h78),
    .TBL_LEN  (TBL_LEN),
    .PWR_DLY  (PWR_DLY),
    .TMO      (TMO)
  ) dut (
    .clk_25M     (clk_25M),
    .camera_rstn (camera_rstn),
    .init_req    (init_req),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .host_req    (host_req),
    .host_data   (host_data),
    .host_gnt    (host_gnt),
    .host_done   (host_done),
    .host_err    (host_err),
    .m_start     (m_start),
    .m_data      (m_data),
    .m_tr_end    (m_tr_end),
    .m_ack       (m_ack),
    .conf_done   (conf_done),
    .init_err    (init_err),
    .busy        (busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #20 clk_25M = ~clk_25M;

  int cyc = 0;
  always @(posedge clk_25M) cyc <= cyc + 1;

  // ---------------- init table ----------------
  logic [23:0] tbl_mem [0:3];
  assign tbl_data = (tbl_addr < 9'd4) ? tbl_mem[tbl_addr[1:0]] : 24'h0;

  function automatic logic [31:0] exp_x(input int idx);
    return {8'h78, tbl_mem[idx]};
  endfunction

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- I2C master model ----------------
  // resp_arr[n] is the response to the n-th transfer: 0 ACK, 1 NACK, 2 silent.
  logic [31:0] xfer_q[$];
  int          rise_q[$];
  int          dur_q[$];
  int          resp_arr [0:63];

  initial begin : master_model
    int n;
    int resp;
    int guard;
    m_tr_end = 1'b0;
    m_ack    = 1'b0;
    forever begin
      @(posedge clk_25M); #1;
      if (m_start === 1'b1) begin
        n    = xfer_q.size();
        resp = (n < 64) ? resp_arr[n] : 0;
        xfer_q.push_back(m_data);
        rise_q.push_back(cyc);
        repeat (3) @(posedge clk_25M);
        #1;
        if (resp != 2 && m_start === 1'b1) begin
          m_ack    = (resp == 1);
          m_tr_end = 1'b1;
        end
        guard = 0;
        while (m_start === 1'b1 && guard < 400) begin
          @(posedge clk_25M); #1;
          guard++;
        end
        dur_q.push_back(cyc - rise_q[rise_q.size()-1]);
        repeat (2) @(posedge clk_25M);
        #1;
        m_tr_end = 1'b0;
        m_ack    = 1'b0;
      end
    end
  end

  // ---------------- host handshake monitor ----------------
  int   gnt_cnt   = 0;
  int   gnt_early = 0;
  int   hd_cnt    = 0;
  logic hd_err    = 1'b0;

  always @(negedge clk_25M) begin
    if (host_gnt === 1'b1) begin
      gnt_cnt++;
      if (conf_done !== 1'b1) gnt_early++;
    end
    if (host_done === 1'b1) begin
      hd_cnt++;
      hd_err = host_err;
    end
  end

  // ---------------- driver tasks ----------------
  int req_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_25M);
    #1;
  endtask

  task automatic pulse_init();
    init_req = 1'b1;
    req_cyc  = cyc + 1;
    tick(1);
    init_req = 1'b0;
  endtask

  task automatic wait_conf(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk_25M);
      if (conf_done === 1'b1) break;
    end
    check("wait_conf_done", {31'h0, conf_done}, 32'h1);
  endtask

  task automatic wait_gnt(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk_25M);
      if (host_gnt === 1'b1) break;
    end
    check("wait_host_gnt", {31'h0, host_gnt}, 32'h1);
  endtask

  task automatic wait_hdone(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk_25M);
      if (host_done === 1'b1) break;
    end
    check("wait_host_done", {31'h0, host_done}, 32'h1);
  endtask

  task automatic wait_mstart(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk_25M);
      if (m_start === 1'b1) break;
    end
    check("wait_m_start", {31'h0, m_start}, 32'h1);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_m_start"},   {31'h0, m_start},   32'h0);
    check({pfx, "_host_gnt"},  {31'h0, host_gnt},  32'h0);
    check({pfx, "_host_done"}, {31'h0, host_done}, 32'h0);
    check({pfx, "_host_err"},  {31'h0, host_err},  32'h0);
    check({pfx, "_conf_done"}, {31'h0, conf_done}, 32'h0);
    check({pfx, "_init_err"},  {31'h0, init_err},  32'h0);
    check({pfx, "_busy"},      {31'h0, busy},      32'h0);
    check({pfx, "_tbl_addr"},  {23'h0, tbl_addr},  32'h0);
    check({pfx, "_m_data"},    m_data,             32'h0);
  endtask

  // ---------------- directed sequence ----------------
  int base;
  int gnt0;
  int hd0;
  int seq [0:5];

  initial begin : stim
    tbl_mem[0] = 24'h3008_82;
    tbl_mem[1] = 24'h3103_03;
    tbl_mem[2] = 24'h3017_ff;
    tbl_mem[3] = 24'h3018_7f;
    for (int i = 0; i < 64; i++) resp_arr[i] = 0;

    // Reset state
    #5;
    check_idle_outputs("rst");
    tick(3);
    camera_rstn = 1'b1;
    tick(5);
    check("idle_without_req", {31'h0, busy}, 32'h0);

    // A: plain init, all ACK
    base = xfer_q.size();
    pulse_init();
    check("busy_in_pwr_wait", {31'h0, busy}, 32'h1);
    wait_conf(400);
    tick(2);
    check("A_first_rise_in_11_12",
          {31'h0, ((rise_q[base] - req_cyc) >= 11) && ((rise_q[base] - req_cyc) <= 12)}, 32'h1);
    check("A_xfer_count", 32'(xfer_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("A_data%0d", i), xfer_q[base+i], exp_x(i));
    check("A_init_err", {31'h0, init_err}, 32'h0);
    check("A_tbl_addr_hold", {23'h0, tbl_addr}, 32'd3);
    check("A_busy_done", {31'h0, busy}, 32'h0);

    // B: entry 2 NACKed twice, then ACKed
    base = xfer_q.size();
    resp_arr[base+2] = 1;
    resp_arr[base+3] = 1;
    pulse_init();
    check("B_conf_cleared", {31'h0, conf_done}, 32'h0);
    wait_conf(600);
    tick(2);
    seq = '{0, 1, 2, 2, 2, 3};
    check("B_xfer_count", 32'(xfer_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("B_data%0d", i), xfer_q[base+i], exp_x(seq[i]));
    check("B_init_err", {31'h0, init_err}, 32'h0);

    // C: entry 2 NACKed three times -> error, entry 3 still sent
    base = xfer_q.size();
    resp_arr[base+2] = 1;
    resp_arr[base+3] = 1;
    resp_arr[base+4] = 1;
    pulse_init();
    wait_conf(600);
    tick(2);
    check("C_xfer_count", 32'(xfer_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("C_data%0d", i), xfer_q[base+i], exp_x(seq[i]));
    check("C_init_err", {31'h0, init_err}, 32'h1);
    check("C_conf_done", {31'h0, conf_done}, 32'h1);

    // D: entry 0 never answered -> three timeouts of TMO cycles
    base = xfer_q.size();
    resp_arr[base+0] = 2;
    resp_arr[base+1] = 2;
    resp_arr[base+2] = 2;
    pulse_init();
    check("D_init_err_cleared", {31'h0, init_err}, 32'h0);
    wait_conf(1200);
    tick(2);
    seq = '{0, 0, 0, 1, 2, 3};
    check("D_xfer_count", 32'(xfer_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("D_data%0d", i), xfer_q[base+i], exp_x(seq[i]));
    for (int i = 0; i < 3; i++)
      check($sformatf("D_tmo_len%0d", i), 32'(dur_q[base+i]), 32'd100);
    check("D_sync_latency", 32'(dur_q[base+3]), 32'd6);
    check("D_init_err", {31'h0, init_err}, 32'h1);

    // E: host request raised during init waits for conf_done
    base = xfer_q.size();
    gnt0 = gnt_cnt;
    hd0  = hd_cnt;
    pulse_init();
    tick(3);
    host_data = 24'h3008_42;
    host_req  = 1'b1;
    wait_gnt(600);
    check("E_gnt_after_conf", {31'h0, conf_done}, 32'h1);
    tick(1);
    host_req = 1'b0;
    wait_hdone(200);
    tick(2);
    check("E_no_early_gnt", 32'(gnt_early), 32'd0);
    check("E_gnt_pulses", 32'(gnt_cnt - gnt0), 32'd1);
    check("E_done_pulses", 32'(hd_cnt - hd0), 32'd1);
    check("E_host_err", {31'h0, hd_err}, 32'h0);
    check("E_xfer_count", 32'(xfer_q.size() - base), 32'd5);
    check("E_host_data", xfer_q[base+4], 32'h7830_0842);
    check("E_busy_done", {31'h0, busy}, 32'h0);

    // E2: host transfer NACKed -> host_err, no retry
    base = xfer_q.size();
    resp_arr[base] = 1;
    host_data = 24'h1234_56;
    host_req  = 1'b1;
    wait_gnt(20);
    tick(1);
    host_req = 1'b0;
    wait_hdone(100);
    tick(20);
    check("E2_host_err", {31'h0, hd_err}, 32'h1);
    check("E2_no_retry", 32'(xfer_q.size() - base), 32'd1);
    check("E2_host_data", xfer_q[base], 32'h7812_3456);
    check("E2_init_err_kept", {31'h0, init_err}, 32'h0);
    check("E2_conf_kept", {31'h0, conf_done}, 32'h1);

    // F: host_req and init_req together in DONE -> host first, then init
    base = xfer_q.size();
    host_data = 24'h3008_42;
    host_req  = 1'b1;
    init_req  = 1'b1;
    wait_gnt(20);
    tick(1);
    host_req = 1'b0;
    wait_hdone(100);
    tick(1);
    check("F_restart_conf_clr", {31'h0, conf_done}, 32'h0);
    check("F_restart_busy", {31'h0, busy}, 32'h1);
    init_req = 1'b0;
    wait_conf(400);
    tick(2);
    check("F_host_err", {31'h0, hd_err}, 32'h0);
    check("F_xfer_count", 32'(xfer_q.size() - base), 32'd5);
    check("F_host_first", xfer_q[base], 32'h7830_0842);
    check("F_init_after", xfer_q[base+1], exp_x(0));

    // G: reset while waiting for the end of a transfer
    base = xfer_q.size();
    resp_arr[base] = 2;
    pulse_init();
    wait_mstart(100);
    tick(3);
    #5;
    camera_rstn = 1'b0;
    #1;
    check_idle_outputs("G_rst");
    tick(2);
    camera_rstn = 1'b1;
    tick(40);
    check("G_idle_busy", {31'h0, busy}, 32'h0);
    check("G_no_resume", {31'h0, m_start}, 32'h0);
    check("G_xfer_count", 32'(xfer_q.size() - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
